ram_readout_ctrl: RTL and testbench
===================================

RAM_READOUT_CTRL -- requirements
Module: ram_readout_ctrl

Interface
REQ-001 The module SHALL have parameter RAM_WIDTH, default 32, word width; only 32 is supported.
REQ-002 The module SHALL have parameter RAM_ADDR_BITS, default 4, RAM address width, giving 16 words.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port Start, input, 1 bit: single-cycle request to begin a readout.
REQ-006 The module SHALL have port StartAddr, input, RAM_ADDR_BITS bits: first word address.
REQ-007 The module SHALL have port WordCnt, input, RAM_ADDR_BITS+1 bits: number of words to read, 0..16.
REQ-008 The module SHALL have port RdAddrs, output, RAM_ADDR_BITS bits: read address driven to the acquisition RAM.
REQ-009 The module SHALL have port RamDat, input, 32 bits: RAM read data, combinational from RdAddrs in the same cycle.
REQ-010 The module SHALL have port ByteOut, output, 8 bits: streamed byte.
REQ-011 The module SHALL have port ByteValid, output, 1 bit: ByteOut is valid.
REQ-012 The module SHALL have port ByteReady, input, 1 bit: the sink accepts the byte.
REQ-013 The module SHALL have port Busy, output, 1 bit: a readout is in progress.
REQ-014 The module SHALL have port Done, output, 1 bit: one-cycle pulse when a readout ends.

Function
REQ-015 The FSM SHALL have states IDLE, FETCH, SEND, CHK (only when the macro is defined) and DONE.
REQ-016 In IDLE, a Start with WordCnt!=0 SHALL latch StartAddr into RdAddrs and WordCnt into the remaining count, then go to FETCH.
REQ-017 In IDLE, a Start with WordCnt==0 SHALL go to DONE without asserting ByteValid.
REQ-018 A Start received in any state other than IDLE SHALL be ignored.
REQ-019 FETCH SHALL last exactly one cycle: it captures RamDat into a 32-bit shift register, clears the byte index, and goes to SEND.
REQ-020 In SEND, ByteValid SHALL be 1 and ByteOut SHALL be shift[31:24], giving MSB-first byte order.
REQ-021 A byte SHALL be transferred only in a cycle where ByteValid and ByteReady are both 1; ByteOut SHALL stay stable until that cycle.
REQ-022 On a transfer with byte index < 3, the shift register SHALL shift left by 8 and the index SHALL increment, staying in SEND.
REQ-023 On a transfer with byte index == 3: if remaining == 1, the FSM SHALL go to CHK when enabled, otherwise to DONE; else it SHALL decrement remaining, increment RdAddrs modulo 16 (15 wraps to 0), and go to FETCH.
REQ-024 DONE SHALL assert Done for exactly one cycle and then return to IDLE.
REQ-025 Busy SHALL be 1 in FETCH, SEND and CHK, and 0 in IDLE and DONE.
REQ-026 Latency: with Start at edge n, the first ByteValid SHALL appear in cycle n+2; with ByteReady held at 1, each word SHALL take 5 cycles, so 16 words take 80 cycles.
REQ-027 RAM writes to a word after its FETCH cycle SHALL NOT alter the bytes of that word already in flight.
REQ-028 RdAddrs SHALL hold its last value in IDLE and DONE.

Reset
REQ-029 With rst=1 at a clock edge, the FSM SHALL go to IDLE and the outputs SHALL become RdAddrs=0, ByteOut=0, ByteValid=0, Busy=0, Done=0.
REQ-030 Reset SHALL also clear the remaining count, the byte index and the checksum.
REQ-031 Reset SHALL take priority over Start and over any transfer in the same cycle.
REQ-032 Asserting reset mid-readout SHALL abort the readout with no Done pulse.

Configuration
REQ-033 The macro RDOUT_CHKSUM_EN SHALL control an optional checksum byte.
REQ-034 When RDOUT_CHKSUM_EN is defined, the checksum SHALL be cleared on an accepted Start and updated as the XOR of every transferred byte.
REQ-035 When RDOUT_CHKSUM_EN is defined, the CHK state SHALL present the checksum on ByteOut with ByteValid=1, and go to DONE when that byte is transferred.
REQ-036 When RDOUT_CHKSUM_EN is not defined, the CHK state and the checksum register SHALL be absent, and the last data byte SHALL lead directly to DONE.

Verification
REQ-037 RAM[2]=0xA1B2C3D4, Start with StartAddr=2 and WordCnt=1, ByteReady=1 -> ByteOut is A1,B2,C3,D4 in cycles n+2..n+5 with RdAddrs=2, then Done; with the macro defined, byte 0x04 follows before Done.
REQ-038 RAM[15]=0x11111111, RAM[0]=0x22222222, Start with StartAddr=15 and WordCnt=2 -> RdAddrs goes 15 then 0; output is four 0x11 bytes then four 0x22 bytes.
REQ-039 ByteReady=0 for 3 cycles while the 2nd byte is presented -> ByteOut and ByteValid are held for those cycles; no byte is lost or duplicated.
REQ-040 Start with WordCnt=0 -> Done is 1 in cycle n+1; ByteValid and Busy stay 0 throughout.
REQ-041 rst=1 while the 3rd byte of word 1 is presented -> in the next cycle ByteValid=0, Busy=0, RdAddrs=0 with no Done; a following Start runs normally.
REQ-042 Start with StartAddr=0 and WordCnt=16, a second Start at cycle 10, ByteReady=1 -> the second Start is ignored; 64 bytes follow in address order 0..15, and Done occurs 80 cycles after the first FETCH.

Source files
------------

// File: rtl/ram_readout_ctrl.sv
// Streams 32-bit words from the acquisition RAM as MSB-first bytes over a valid/ready link.
// Optional trailing XOR checksum byte enabled with the RDOUT_CHKSUM_EN macro.
module ram_readout_ctrl #(
   parameter int unsigned RAM_WIDTH     = 32,
   parameter int unsigned RAM_ADDR_BITS = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     Start,
   input  logic [RAM_ADDR_BITS-1:0] StartAddr,
   input  logic [RAM_ADDR_BITS:0]   WordCnt,
   output logic [RAM_ADDR_BITS-1:0] RdAddrs,
   input  logic [RAM_WIDTH-1:0]     RamDat,
   output logic [7:0]               ByteOut,
   output logic                     ByteValid,
   input  logic                     ByteReady,
   output logic                     Busy,
   output logic                     Done
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      SEND,
`ifdef RDOUT_CHKSUM_EN
      CHK,
`endif
      DONE
   } state_t;

   localparam logic [RAM_ADDR_BITS:0]   REM_ONE  = 1;
   localparam logic [RAM_ADDR_BITS-1:0] ADDR_ONE = 1;

   state_t                   state_q, state_d;
   logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
   logic [RAM_ADDR_BITS:0]   rem_q, rem_d;
   logic [1:0]               idx_q, idx_d;
   logic [RAM_WIDTH-1:0]     shift_q, shift_d;
`ifdef RDOUT_CHKSUM_EN
   logic [7:0]               chk_q, chk_d;
`endif
   logic [7:0]               byte_out_q, byte_out_d;
   logic                     byte_valid_q, byte_valid_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic                     xfer;

   assign xfer = byte_valid_q & ByteReady;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      idx_d   = idx_q;
      shift_d = shift_q;
`ifdef RDOUT_CHKSUM_EN
      chk_d   = chk_q;
`endif
      case (state_q)
         IDLE: begin
            if (Start) begin
`ifdef RDOUT_CHKSUM_EN
               chk_d = '0;
`endif
               if (WordCnt != '0) begin
                  addr_d  = StartAddr;
                  rem_d   = WordCnt;
                  state_d = FETCH;
               end else begin
                  state_d = DONE;
               end
            end
         end
         FETCH: begin
            shift_d = RamDat;
            idx_d   = '0;
            state_d = SEND;
         end
         SEND: begin
            if (xfer) begin
`ifdef RDOUT_CHKSUM_EN
               chk_d = chk_q ^ shift_q[RAM_WIDTH-1 -: 8];
`endif
               if (idx_q != 2'd3) begin
                  shift_d = shift_q << 8;
                  idx_d   = idx_q + 2'd1;
               end else if (rem_q == REM_ONE) begin
`ifdef RDOUT_CHKSUM_EN
                  state_d = CHK;
`else
                  state_d = DONE;
`endif
               end else begin
                  rem_d   = rem_q - REM_ONE;
                  addr_d  = addr_q + ADDR_ONE;
                  state_d = FETCH;
               end
            end
         end
`ifdef RDOUT_CHKSUM_EN
         CHK: begin
            if (xfer) state_d = DONE;
         end
`endif
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next-state values so they register in step with the state.
   always_comb begin
      byte_valid_d = 1'b0;
      byte_out_d   = '0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      case (state_d)
         FETCH: busy_d = 1'b1;
         SEND: begin
            busy_d       = 1'b1;
            byte_valid_d = 1'b1;
            byte_out_d   = shift_d[RAM_WIDTH-1 -: 8];
         end
`ifdef RDOUT_CHKSUM_EN
         CHK: begin
            busy_d       = 1'b1;
            byte_valid_d = 1'b1;
            byte_out_d   = chk_d;
         end
`endif
         DONE:    done_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         rem_q        <= '0;
         idx_q        <= '0;
         shift_q      <= '0;
`ifdef RDOUT_CHKSUM_EN
         chk_q        <= '0;
`endif
         byte_out_q   <= '0;
         byte_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         rem_q        <= rem_d;
         idx_q        <= idx_d;
         shift_q      <= shift_d;
`ifdef RDOUT_CHKSUM_EN
         chk_q        <= chk_d;
`endif
         byte_out_q   <= byte_out_d;
         byte_valid_q <= byte_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign RdAddrs   = addr_q;
   assign ByteOut   = byte_out_q;
   assign ByteValid = byte_valid_q;
   assign Busy      = busy_q;
   assign Done      = done_q;

endmodule

// File: tb/tb_ram_readout_ctrl.sv
// Bench for ram_readout_ctrl: table of readouts plus reset sequences, bytes checked against a queue.
// Honours RDOUT_CHKSUM_EN to expect the trailing checksum byte.
module tb_ram_readout_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        Start;
   logic [3:0]  StartAddr;
   logic [4:0]  WordCnt;
   logic [3:0]  RdAddrs;
   logic [31:0] RamDat;
   logic [7:0]  ByteOut;
   logic        ByteValid;
   logic        ByteReady;
   logic        Busy;
   logic        Done;

   logic [31:0] ram [16];

`ifdef RDOUT_CHKSUM_EN
   localparam int CHK_EXTRA = 1;
`else
   localparam int CHK_EXTRA = 0;
`endif

   typedef struct {
      logic [7:0] b;
      logic [3:0] a;
   } exp_t;

   typedef struct {
      logic [3:0] addr;
      logic [4:0] cnt;
      int         lat;        // cycles from Start edge to Done, without checksum byte
      int         stall_byte;
      int         stall_len;
      int         ss_cyc;     // cycle of an extra Start that must be ignored
      int         poke_cyc;   // cycle at which the word in flight is overwritten in RAM
   } vec_t;

   exp_t        sb[$];
   int          ncmp = 0;
   int          errs = 0;
   int          npop = 0;
   logic        prev_valid = 1'b0;
   logic        prev_rdy = 1'b0;
   logic [7:0]  prev_out = '0;

   ram_readout_ctrl #(.RAM_WIDTH(32), .RAM_ADDR_BITS(4)) dut (
      .clk(clk), .rst(rst), .Start(Start), .StartAddr(StartAddr), .WordCnt(WordCnt),
      .RdAddrs(RdAddrs), .RamDat(RamDat), .ByteOut(ByteOut), .ByteValid(ByteValid),
      .ByteReady(ByteReady), .Busy(Busy), .Done(Done)
   );

   assign RamDat = ram[RdAddrs];

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_expected(input logic [3:0] addr, input logic [4:0] cnt);
      logic [7:0]  x;
      logic [3:0]  a;
      logic [31:0] w;
      exp_t        e;
      x = '0;
      a = addr;
      for (int unsigned k = 0; k < cnt; k++) begin
         a = addr + 4'(k);
         w = ram[a];
         for (int unsigned b = 0; b < 4; b++) begin
            e.b = w[31:24];
            e.a = a;
            sb.push_back(e);
            x = x ^ w[31:24];
            w = w << 8;
         end
      end
      if (CHK_EXTRA != 0 && cnt != 0) begin
         e.b = x;
         e.a = a;
         sb.push_back(e);
      end
   endtask

   // Checks the presented byte (popped if it transfers this cycle), then advances one edge.
   task automatic step(input logic rdy);
      exp_t e;
      ByteReady = rdy;
      if (ByteValid && rdy) begin
         if (sb.size() == 0) begin
            ncmp++;
            errs++;
            $display("FAIL extra_byte: got %h expected no byte", ByteOut);
         end else begin
            e = sb.pop_front();
            npop++;
            chk("byte", ByteOut, e.b);
            chk("rdaddr", RdAddrs, e.a);
         end
      end
      if (prev_valid && !prev_rdy) begin
         chk("hold_valid", ByteValid, 1'b1);
         chk("hold_byte", ByteOut, prev_out);
      end
      prev_valid = ByteValid;
      prev_rdy   = rdy;
      prev_out   = ByteOut;
      @(posedge clk);
      #1;
   endtask

   task automatic run_readout(input vec_t v);
      int   expl;
      int   base;
      int   stall_left;
      logic rdy;
      expl = v.lat + ((v.cnt != 0) ? CHK_EXTRA : 0);
      push_expected(v.addr, v.cnt);
      Start     = 1'b1;
      StartAddr = v.addr;
      WordCnt   = v.cnt;
      base       = npop;
      stall_left = v.stall_len;
      step(1'b1);
      for (int c = 1; c <= expl + 2; c++) begin
         Start = (c == v.ss_cyc);
         if (Start) begin
            StartAddr = 4'd5;
            WordCnt   = 5'd3;
         end
         if (c == v.poke_cyc) ram[v.addr] = ~ram[v.addr];
         chk("done", Done, c == expl);
         chk("busy", Busy, (v.cnt != 0) && (c < expl));
         if (c <= 2 || c >= expl) chk("valid", ByteValid, (v.cnt != 0) && (c == 2));
         rdy = 1'b1;
         if (npop - base == v.stall_byte && ByteValid && stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
         end
         step(rdy);
      end
      Start = 1'b0;
      chk("sb_empty", sb.size(), 0);
   endtask

   vec_t vecs[7];

   initial begin
      int base;
      vecs[0] = '{addr: 4'd2,  cnt: 5'd1,  lat: 6,  stall_byte: -1, stall_len: 0, ss_cyc: -1, poke_cyc: -1};
      vecs[1] = '{addr: 4'd15, cnt: 5'd2,  lat: 11, stall_byte: -1, stall_len: 0, ss_cyc: -1, poke_cyc: -1};
      vecs[2] = '{addr: 4'd3,  cnt: 5'd2,  lat: 14, stall_byte: 1,  stall_len: 3, ss_cyc: -1, poke_cyc: -1};
      vecs[3] = '{addr: 4'd7,  cnt: 5'd0,  lat: 1,  stall_byte: -1, stall_len: 0, ss_cyc: -1, poke_cyc: -1};
      vecs[4] = '{addr: 4'd0,  cnt: 5'd16, lat: 81, stall_byte: -1, stall_len: 0, ss_cyc: 10, poke_cyc: -1};
      vecs[5] = '{addr: 4'd9,  cnt: 5'd1,  lat: 6,  stall_byte: -1, stall_len: 0, ss_cyc: -1, poke_cyc: 3};
      vecs[6] = '{addr: 4'd12, cnt: 5'd5,  lat: 28, stall_byte: 6,  stall_len: 2, ss_cyc: -1, poke_cyc: -1};

      for (int unsigned i = 0; i < 16; i++) ram[i] = $urandom;
      ram[2]  = 32'hA1B2C3D4;
      ram[15] = 32'h11111111;
      ram[0]  = 32'h22222222;

      rst = 1'b1; Start = 1'b0; StartAddr = '0; WordCnt = '0; ByteReady = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_rdaddr", RdAddrs, 0);
      chk("rst_byteout", ByteOut, 0);
      chk("rst_valid", ByteValid, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_done", Done, 0);
      rst = 1'b0;
      step(1'b1);

      for (int unsigned i = 0; i < 7; i++) run_readout(vecs[i]);

      // Reset while the third byte of the first word is presented; Start shares the edge.
      push_expected(4'd4, 5'd2);
      Start = 1'b1; StartAddr = 4'd4; WordCnt = 5'd2;
      base = npop;
      step(1'b1);
      Start = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (npop - base == 2 && ByteValid) break;
         step(1'b1);
      end
      chk("abort_point", npop - base, 2);
      rst = 1'b1; ByteReady = 1'b1; Start = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; Start = 1'b0;
      chk("abort_valid", ByteValid, 0);
      chk("abort_busy", Busy, 0);
      chk("abort_rdaddr", RdAddrs, 0);
      chk("abort_done", Done, 0);
      sb.delete();
      prev_valid = 1'b0;
      step(1'b1);
      chk("abort_done2", Done, 0);
      chk("abort_busy2", Busy, 0);
      run_readout('{addr: 4'd6, cnt: 5'd1, lat: 6, stall_byte: -1, stall_len: 0, ss_cyc: -1, poke_cyc: -1});

      $display("== %0d vectors applied, %0d miscompares ==", ncmp, errs);
      $finish;
   end

endmodule
